// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the IF stage: NOP encoding, default reset PC,
// sequencing states and the entry formats held in the in-flight and response queues.
package fetch_stage_pkg;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      FS_IDLE,
      FS_RUN,
      FS_MISAL,
      FS_HALT
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } fetch_entry_t;

   typedef struct packed {
      logic        epoch;
      logic [31:0] pc;
   } inflight_t;

endpackage

// File: rtl/fetch_buffer.sv
// Parametric synchronous FIFO with flush, used both for the in-flight request
// queue and the instruction response buffer.
module fetch_buffer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             wdata,
   output logic [WIDTH-1:0]             rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign rdata = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == ($clog2(DEPTH+1))'(DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= nxt(wr_ptr);
         if (pop)  rd_ptr <= nxt(rd_ptr);
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues in-order word fetches, filters wrong-path
// responses by epoch, buffers them and drives the IF/ID register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter int unsigned MAX_OUTSTD = 2,
   parameter int unsigned BUF_DEPTH  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic [31:0] if_id_instr,
   output logic        if_id_fault
);

   localparam int unsigned OW = $clog2(MAX_OUTSTD + 1);
   localparam int unsigned BW = $clog2(BUF_DEPTH + 1);

   fetch_state_e state;
   logic [31:0]  fetch_pc;
   logic         epoch;

   inflight_t    infl_head;
   inflight_t    infl_wdata;
   logic [OW-1:0] outstanding;
   logic         infl_full;
   logic         infl_empty;

   fetch_entry_t buf_head;
   fetch_entry_t rsp_entry;
   fetch_entry_t ifid_next;
   logic [BW-1:0] buf_count;
   logic         buf_full;
   logic         buf_empty;

   logic accept;
   logic rsp_pop;
   logic rsp_live;
   logic advance;
   logic bypass;
   logic buf_push;
   logic buf_pop;
   logic ifid_has;

   // Credit check: in-flight plus buffered never exceeds buffer capacity.
   assign imem_req_valid = (state == FS_RUN) && !redirect && !infl_full &&
                           (32'(outstanding) + 32'(buf_count) < BUF_DEPTH);
   assign imem_req_addr  = fetch_pc;
   assign accept         = imem_req_valid && imem_req_ready;
   assign infl_wdata     = '{epoch: epoch, pc: fetch_pc};

   assign rsp_pop   = imem_rsp_valid && !infl_empty;
   assign rsp_live  = rsp_pop && (infl_head.epoch == epoch) && !redirect;
   assign rsp_entry = '{pc:    infl_head.pc,
                        instr: imem_rsp_err ? NOP_INSTR : imem_rsp_data,
                        fault: imem_rsp_err};

   // An empty buffer lets a live response go straight into IF/ID.
   assign advance  = !redirect && !stall;
   assign bypass   = advance && buf_empty && (state != FS_MISAL);
   assign buf_push = rsp_live && !bypass && !buf_full;
   assign buf_pop  = advance && !buf_empty && (state != FS_MISAL);

   always_comb begin
      ifid_next = '{pc: if_id_pc, instr: NOP_INSTR, fault: 1'b0};
      ifid_has  = 1'b1;
      if (state == FS_MISAL)  ifid_next = '{pc: fetch_pc, instr: NOP_INSTR, fault: 1'b1};
      else if (!buf_empty)    ifid_next = buf_head;
      else if (rsp_live)      ifid_next = rsp_entry;
      else                    ifid_has  = 1'b0;
   end

   fetch_buffer #(.WIDTH($bits(inflight_t)), .DEPTH(MAX_OUTSTD)) u_inflight (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (accept),
      .pop   (rsp_pop),
      .flush (1'b0),
      .wdata (infl_wdata),
      .rdata (infl_head),
      .count (outstanding),
      .full  (infl_full),
      .empty (infl_empty)
   );

   fetch_buffer #(.WIDTH($bits(fetch_entry_t)), .DEPTH(BUF_DEPTH)) u_rsp_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (buf_push),
      .pop   (buf_pop),
      .flush (redirect),
      .wdata (rsp_entry),
      .rdata (buf_head),
      .count (buf_count),
      .full  (buf_full),
      .empty (buf_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FS_IDLE;
         fetch_pc <= RESET_PC;
         epoch    <= 1'b0;
      end else if (redirect) begin
         fetch_pc <= redirect_pc;
         epoch    <= ~epoch;
         state    <= (redirect_pc[1:0] != 2'b00) ? FS_MISAL : FS_RUN;
      end else begin
         case (state)
            FS_IDLE:  state <= FS_RUN;
            FS_RUN:   if (accept) fetch_pc <= fetch_pc + 32'd4;
            FS_MISAL: if (!stall) state <= FS_HALT;
            FS_HALT:  ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_id_valid    <= 1'b0;
         if_id_pc       <= RESET_PC;
         if_id_pc_plus4 <= RESET_PC + 32'd4;
         if_id_instr    <= NOP_INSTR;
         if_id_fault    <= 1'b0;
      end else if (redirect) begin
         if_id_valid <= 1'b0;
         if_id_instr <= NOP_INSTR;
         if_id_fault <= 1'b0;
      end else if (!stall) begin
         if_id_valid <= ifid_has;
         if_id_instr <= ifid_next.instr;
         if_id_fault <= ifid_next.fault;
         if (ifid_has) begin
            if_id_pc       <= ifid_next.pc;
            if_id_pc_plus4 <= ifid_next.pc + 32'd4;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: queue-based reference model plus an
// in-order memory with randomized ready/latency/errors, and directed scenarios.
module tb_fetch_stage;

   localparam int unsigned MAX_OUTSTD = 2;
   localparam int unsigned BUF_DEPTH  = 2;
   localparam logic [31:0] RST_PC     = 32'h0000_0000;
   localparam logic [31:0] NOP        = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic [31:0] if_id_instr;
   logic        if_id_fault;

   fetch_stage #(.RESET_PC(RST_PC), .MAX_OUTSTD(MAX_OUTSTD), .BUF_DEPTH(BUF_DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .stall          (stall),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .if_id_valid    (if_id_valid),
      .if_id_pc       (if_id_pc),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_instr    (if_id_instr),
      .if_id_fault    (if_id_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      bit          fault;
   } ent_t;

   typedef struct packed {
      logic        ep;
      logic [31:0] pc;
   } inf_t;

   typedef struct {
      logic [31:0] addr;
      bit          err;
      int unsigned due;
   } mem_t;

   int total = 0;
   int bad   = 0;

   // reference model
   logic [31:0] m_pc;
   bit          m_epoch;
   bit          m_started;
   bit          m_fetching;
   bit          m_fault_pend;
   bit          m_ifid_v;
   ent_t        m_ifid;
   inf_t        m_inf[$];
   ent_t        m_buf[$];

   // memory
   mem_t        mq[$];
   int unsigned cyc;
   int unsigned last_due;
   int unsigned ready_pct;
   int unsigned lat_lo;
   int unsigned lat_hi;
   int unsigned err_pct;
   bit          err_on;
   logic [31:0] err_addr;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void model_reset();
      m_pc         = RST_PC;
      m_epoch      = 1'b0;
      m_started    = 1'b0;
      m_fetching   = 1'b0;
      m_fault_pend = 1'b0;
      m_ifid_v     = 1'b0;
      m_ifid       = '{pc: RST_PC, instr: NOP, fault: 1'b0};
      m_inf.delete();
      m_buf.delete();
      mq.delete();
      last_due     = 0;
   endfunction

   // One cycle: drive at negedge, check, update model at posedge, return at next negedge.
   task automatic tick(input bit s, input bit r, input logic [31:0] rp);
      bit   exp_req;
      bit   acc;
      bit   live;
      bit   used;
      inf_t h;
      ent_t e;
      mem_t m;
      stall          = s;
      redirect       = r;
      redirect_pc    = rp;
      imem_req_ready = ($urandom_range(99) < ready_pct);
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mdata(mq[0].addr);
         imem_rsp_err   = mq[0].err;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
         imem_rsp_err   = 1'($urandom_range(1));
      end
      exp_req = m_fetching && !r && (m_inf.size() < MAX_OUTSTD) &&
                (m_inf.size() + m_buf.size() < BUF_DEPTH);
      #1;
      chk("req_valid", imem_req_valid, exp_req);
      if (exp_req) chk("req_addr", imem_req_addr, m_pc);
      chk("if_id_valid", if_id_valid, m_ifid_v);
      if (m_ifid_v) begin
         chk("if_id_pc", if_id_pc, m_ifid.pc);
         chk("if_id_pc_plus4", if_id_pc_plus4, m_ifid.pc + 32'd4);
      end
      chk("if_id_instr", if_id_instr, m_ifid_v ? m_ifid.instr : NOP);
      chk("if_id_fault", if_id_fault, m_ifid_v ? m_ifid.fault : 1'b0);

      @(posedge clk);
      acc  = exp_req && imem_req_ready;
      live = 1'b0;
      used = 1'b0;
      e    = '{pc: '0, instr: NOP, fault: 1'b0};
      if (imem_rsp_valid) begin
         void'(mq.pop_front());
         if (m_inf.size() > 0) begin
            h       = m_inf.pop_front();
            live    = (h.ep == m_epoch) && !r;
            e.pc    = h.pc;
            e.fault = imem_rsp_err;
            e.instr = imem_rsp_err ? NOP : mdata(h.pc);
         end
      end
      if (acc) begin
         m_inf.push_back('{ep: m_epoch, pc: m_pc});
         m.addr = m_pc;
         m.err  = (err_on && m_pc == err_addr) || ($urandom_range(99) < err_pct);
         m.due  = cyc + $urandom_range(lat_hi, lat_lo);
         if (m.due < last_due) m.due = last_due;
         last_due = m.due;
         mq.push_back(m);
         m_pc = m_pc + 32'd4;
      end
      if (r) begin
         m_pc     = rp;
         m_epoch  = !m_epoch;
         m_buf.delete();
         m_ifid_v = 1'b0;
         m_ifid.instr = NOP;
         m_ifid.fault = 1'b0;
         m_started    = 1'b1;
         m_fault_pend = (rp[1:0] != 2'b00);
         m_fetching   = (rp[1:0] == 2'b00);
      end else begin
         if (!m_started) begin
            m_started  = 1'b1;
            m_fetching = 1'b1;
         end
         if (!s) begin
            if (m_fault_pend) begin
               m_ifid       = '{pc: m_pc, instr: NOP, fault: 1'b1};
               m_ifid_v     = 1'b1;
               m_fault_pend = 1'b0;
            end else if (m_buf.size() > 0) begin
               m_ifid   = m_buf.pop_front();
               m_ifid_v = 1'b1;
            end else if (live) begin
               m_ifid   = e;
               m_ifid_v = 1'b1;
               used     = 1'b1;
            end else begin
               m_ifid_v     = 1'b0;
               m_ifid.instr = NOP;
               m_ifid.fault = 1'b0;
            end
         end
         if (live && !used) m_buf.push_back(e);
      end
      @(negedge clk);
      cyc++;
   endtask

   // Asserts reset asynchronously mid-cycle; caller is at a negedge.
   task automatic do_reset();
      #3;
      rst_n          = 1'b0;
      stall          = 1'b0;
      redirect       = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      #1;
      chk("rst_req_valid", imem_req_valid, 1'b0);
      chk("rst_if_id_valid", if_id_valid, 1'b0);
      chk("rst_if_id_pc", if_id_pc, RST_PC);
      chk("rst_if_id_pc_plus4", if_id_pc_plus4, RST_PC + 32'd4);
      chk("rst_if_id_instr", if_id_instr, NOP);
      chk("rst_if_id_fault", if_id_fault, 1'b0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_valid(input int bound);
      for (int n = 0; n < bound && !if_id_valid; n++) tick(1'b0, 1'b0, '0);
   endtask

   initial begin
      logic [31:0] p;
      logic [31:0] rp;
      rst_n          = 1'b0;
      stall          = 1'b0;
      redirect       = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
      cyc            = 0;
      ready_pct      = 100;
      lat_lo         = 1;
      lat_hi         = 1;
      err_pct        = 0;
      err_on         = 1'b0;
      err_addr       = '0;
      model_reset();
      @(negedge clk);
      do_reset();

      // sequential fetch with a 1-cycle memory
      tick(1'b0, 1'b0, '0);
      chk("t1_first_req", imem_req_valid, 1'b1);
      chk("t1_addr0", imem_req_addr, 32'h0);
      tick(1'b0, 1'b0, '0);
      chk("t1_addr4", imem_req_addr, 32'h4);
      tick(1'b0, 1'b0, '0);
      chk("t1_pc0", if_id_pc, 32'h0);
      chk("t1_pc0_plus4", if_id_pc_plus4, 32'h4);
      chk("t1_instr0", if_id_instr, mdata(32'h0));
      chk("t1_addr8", imem_req_addr, 32'h8);
      tick(1'b0, 1'b0, '0);
      chk("t1_pc4", if_id_pc, 32'h4);
      chk("t1_valid4", if_id_valid, 1'b1);
      repeat (3) tick(1'b0, 1'b0, '0);

      // stall holds IF/ID; nothing lost on release
      p = if_id_pc;
      repeat (3) begin
         tick(1'b1, 1'b0, '0);
         chk("t2_held_pc", if_id_pc, p);
      end
      tick(1'b0, 1'b0, '0);
      chk("t2_next_pc", if_id_pc, p + 32'd4);
      repeat (4) tick(1'b0, 1'b0, '0);

      // redirect with two fetches in flight
      lat_lo = 2;
      lat_hi = 2;
      repeat (6) tick(1'b0, 1'b0, '0);
      tick(1'b0, 1'b1, 32'h0000_0100);
      chk("t3_cleared", if_id_valid, 1'b0);
      wait_valid(20);
      chk("t3_target_pc", if_id_pc, 32'h0000_0100);

      // redirect beats stall
      tick(1'b1, 1'b1, 32'h0000_0200);
      chk("t4_cleared", if_id_valid, 1'b0);
      chk("t4_nop", if_id_instr, NOP);
      wait_valid(20);
      chk("t4_target_pc", if_id_pc, 32'h0000_0200);

      // bus error entry, then misaligned redirect
      lat_lo   = 1;
      lat_hi   = 1;
      err_on   = 1'b1;
      err_addr = 32'h8;
      tick(1'b0, 1'b1, 32'h0);
      for (int n = 0; n < 20 && !(if_id_valid && if_id_pc == 32'h8); n++) tick(1'b0, 1'b0, '0);
      chk("t5_err_pc", if_id_pc, 32'h8);
      chk("t5_err_fault", if_id_fault, 1'b1);
      chk("t5_err_instr", if_id_instr, NOP);
      err_on = 1'b0;
      tick(1'b0, 1'b1, 32'h0000_0102);
      chk("t5_mis_cleared", if_id_valid, 1'b0);
      chk("t5_mis_noreq", imem_req_valid, 1'b0);
      tick(1'b0, 1'b0, '0);
      chk("t5_mis_valid", if_id_valid, 1'b1);
      chk("t5_mis_fault", if_id_fault, 1'b1);
      chk("t5_mis_pc", if_id_pc, 32'h0000_0102);
      chk("t5_mis_instr", if_id_instr, NOP);
      repeat (4) begin
         tick(1'b0, 1'b0, '0);
         chk("t5_halt_noreq", imem_req_valid, 1'b0);
      end

      // address wrap, then async reset mid-burst
      tick(1'b0, 1'b1, 32'hFFFF_FFF8);
      for (int n = 0; n < 20 && !(if_id_valid && if_id_pc == 32'hFFFF_FFFC); n++) tick(1'b0, 1'b0, '0);
      chk("t6_top_pc", if_id_pc, 32'hFFFF_FFFC);
      tick(1'b0, 1'b0, '0);
      chk("t6_wrap_valid", if_id_valid, 1'b1);
      chk("t6_wrap_pc", if_id_pc, 32'h0);
      chk("t6_wrap_plus4", if_id_pc_plus4, 32'h4);
      do_reset();
      tick(1'b0, 1'b0, '0);
      chk("t6_restart_req", imem_req_valid, 1'b1);
      chk("t6_restart_addr", imem_req_addr, RST_PC);

      // randomized traffic
      ready_pct = 60;
      lat_lo    = 1;
      lat_hi    = 4;
      err_pct   = 5;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         rp = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(7) == 0) rp[1:0] = 2'($urandom_range(3, 1));
         tick($urandom_range(99) < 25, $urandom_range(99) < 5, rp);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
